// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchroniser, centre sampling of each bit,
// and a one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int freq_hz  = 100_000_000,
  parameter int baudrate = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] odata,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TicksPerBaud = freq_hz / baudrate;
  localparam int HalfBaud     = TicksPerBaud / 2;
  localparam int CntW         = $clog2(TicksPerBaud) + 1;

  localparam logic [CntW-1:0] CntLast = CntW'(TicksPerBaud - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfBaud - 1);

  if (TicksPerBaud < 4) begin : g_bad_baud
    $error("uart_rx: ticks_per_baud must be at least 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            deliver;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 4'd0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CntLast) begin
          shift_d[bit_idx_q[2:0]] = rx_s;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at the stop-bit centre keeps half a bit of margin for the next start edge.
        if (cnt_q == CntLast) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 4'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign odata     = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 ticks per bit; expected bytes are queued when a frame is
// driven and compared in order whenever the DUT hands a byte over.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] odata;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx #(.freq_hz(16), .baudrate(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .odata     (odata),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Handshakes are judged mid-cycle; the byte is consumed on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && ready) begin
        hs_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %02h, expected none", odata);
        end else begin
          exp_b = exp_q.pop_front();
          if (odata !== exp_b) begin
            n_fail++;
            $display("FAIL rx_byte: got %02h, expected %02h", odata, exp_b);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(16);
    end
    rx = stop_bit;
    tick(16);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks += 5;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    if (odata !== 8'h00) begin n_fail++; $display("FAIL reset_odata: got %02h, expected 00", odata); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    int hs0, fe0;
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(4);
    wait_drain("basic");
    n_checks += 3;
    if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d, expected 1", hs_cnt - hs0); end
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d, expected 0", fe_cnt - fe0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    tick(4);
    n_checks += 2;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b, expected 1", valid); end
    if (odata !== 8'h3C) begin n_fail++; $display("FAIL hold_odata: got %02h, expected 3c", odata); end
    send_frame(8'hFF, 1'b1);
    tick(4);
    n_checks += 3;
    if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d, expected 1", ov_cnt - ov0); end
    if (odata !== 8'h3C) begin n_fail++; $display("FAIL overrun_odata: got %02h, expected 3c", odata); end
    if (valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b, expected 1", valid); end
    exp_q.push_back(8'h3C);
    ready = 1'b1;
    tick(1);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL consume_valid: got %b, expected 0", valid); end
    wait_drain("overrun");
  endtask

  task automatic test_frame_err();
    int hs0, fe0;
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    ready = 1'b1;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    tick(24);
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b, expected 1", busy); end
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL frame_err_cycles: got %0d, expected 1", fe_cnt - fe0); end
    if (hs_cnt - hs0 !== 0) begin n_fail++; $display("FAIL frame_err_valid: got %0d, expected 0", hs_cnt - hs0); end
    rx = 1'b1;
    tick(6);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release_busy: got %b, expected 0", busy); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(4);
    wait_drain("after_break");
  endtask

  task automatic test_glitch();
    int hs0, fe0, bc;
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    bc  = 0;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy) bc++;
    end
    n_checks += 4;
    if (bc < 1 || bc > 10) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d, expected 1..10", bc); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b, expected 0", busy); end
    if (hs_cnt - hs0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d, expected 0", hs_cnt - hs0); end
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int fe0;
    d = 8'h81;
    ready = 1'b0;
    send_frame(8'h99, 1'b1);
    tick(4);
    n_checks++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b, expected 1", valid); end
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = d[4];
    tick(8);
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, expected 0", valid); end
    if (odata !== 8'h00) begin n_fail++; $display("FAIL midreset_odata: got %02h, expected 00", odata); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    fe0 = fe_cnt;
    tick(32);
    n_checks += 3;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b, expected 0", valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, expected 0", busy); end
    if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL post_reset_frame_err: got %0d, expected 0", fe_cnt - fe0); end
    ready = 1'b1;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    tick(4);
    wait_drain("post_reset");
  endtask

  task automatic test_back_to_back();
    int hs0;
    logic [7:0] frames [3];
    frames[0] = 8'h00;
    frames[1] = 8'hFF;
    frames[2] = 8'h01;
    hs0 = hs_cnt;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(frames[i]);
      send_frame(frames[i], 1'b1);
    end
    tick(4);
    wait_drain("back_to_back");
    n_checks++;
    if (hs_cnt - hs0 !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d, expected 3", hs_cnt - hs0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
